partition_output_arbiter: RTL and testbench
===========================================

// Module: partition_output_arbiter
// PURPOSE
//  Shares one downstream partition-writer port among NUM_IN routed tuple streams, e.g. the Gate outputs of one partition.
//  Round-robin grant with bounded bursts, so one stream cannot starve the others.
//  Tracks per-stream end-of-input and raises all_done once every stream has finished and the output has drained.
// PARAMETERS
//  NUM_IN      4   number of requesting tuple streams (>=2)
//  INPUT_SIZE  64  tuple data width in bits
//  MAX_BURST   8   max beats accepted from one stream per grant (>=1)
// PORTS
//  clk           in   1                clock
//  resetn        in   1                synchronous reset, active-low
//  in_valid      in   NUM_IN           per-stream tuple valid
//  in_data       in   NUM_IN*INPUT_SIZE per-stream tuple data
//  in_tag        in   NUM_IN*32        per-stream hash tag
//  in_last       in   NUM_IN           beat is final tuple of that stream (qualified by in_valid)
//  in_ready      out  NUM_IN           per-stream accept
//  out_ready     in   1                downstream can take a beat
//  out_valid     out  1                output beat valid
//  out_data      out  INPUT_SIZE       forwarded tuple
//  out_tag       out  32               forwarded tag
//  out_src       out  $clog2(NUM_IN)   index of source stream
//  out_burst_end out  1                last beat of current grant
//  all_done      out  1                all streams finished, output empty
// BEHAVIOUR
//  - Reset: all outputs 0, in_ready 0, rr_ptr=0, burst_cnt=0, finished[]=0, state=IDLE.
//  - Output register: load_en = ~out_valid | out_ready; beat accepted from owner when in_valid[owner] & in_ready[owner].
//  - Accepted beat appears on out_* next cycle (latency 1). out_valid drops when out_ready and no new beat accepted.
//  - in_ready[i] = (state==GRANT) & (owner==i) & load_en; all others 0. No combinational in_valid->in_ready path.
//  - FSM IDLE: owner = first i at or after rr_ptr (cyclic) with in_valid[i] & ~finished[i].
//    If found: latch owner, burst_cnt=0 -> GRANT. Else stay IDLE.
//    Exactly one IDLE cycle (bubble) between grants.
//  - FSM GRANT: each accepted beat increments burst_cnt.
//    Release -> IDLE, rr_ptr=owner+1 (wraps NUM_IN-1 -> 0), when:
//      (a) accepted beat makes burst_cnt==MAX_BURST;
//      (b) accepted beat has in_last; or
//      (c) in_valid[owner]=0 while load_en=1.
//    out_burst_end=1 on the beat that triggers (a) or (b).
//    For (c) the next beat carries out_burst_end=0.
//  - burst_cnt width $clog2(MAX_BURST+1); never exceeds MAX_BURST.
//  - finished[i] set on accepted beat with in_last[i]; a finished stream is never granted again. Sticky until reset.
//  - When all finished=1 and out_valid=0 -> DONE: all_done=1, in_ready=0, held until reset.
//  - out_ready=0 in GRANT: hold owner, burst_cnt and out_*; no release by (c).
//  - Reset mid-burst: everything returns to reset values next edge. In-flight output beat is discarded.
// CONFIGURATION
//  - ARB_BEAT_COUNT_EN defined: adds port beat_count out NUM_IN*32.
//    It holds a per-stream count of accepted beats, reset 0, wrapping at 2^32.
//  - Undefined: port and counters absent; all other behaviour is identical.
// TESTING
//  1. NUM_IN=4, only stream 2 valid, 3 beats, out_ready=1:
//     -> IDLE 1 cycle, beats out with out_src=2 on consecutive cycles, latency 1.
//  2. All 4 streams continuously valid, MAX_BURST=8:
//     -> 8 beats each in order src 0,1,2,3,0; out_burst_end on each 8th beat; 1 bubble between.
//  3. Stream 0 in burst, out_ready low 5 cycles:
//     -> out_* stable, in_ready all 0, burst_cnt unchanged; resumes without loss.
//  4. Stream 1 sends 3 beats, 3rd with in_last:
//     -> out_burst_end on beat 3, stream 1 never granted again even if in_valid=1.
//  5. All streams send in_last, final beat accepted:
//     -> all_done=1 the cycle after out_valid falls; stays 1.
//  6. resetn low mid-burst (burst_cnt=4):
//     -> next cycle out_valid=0, all_done=0, next grant starts from stream 0.

Source files
------------

// File: rtl/partition_output_arbiter.sv
// Round-robin arbiter sharing one partition-writer port among NUM_IN tuple streams,
// with bounded bursts and end-of-input tracking. Optional per-stream beat counters: ARB_BEAT_COUNT_EN.
module partition_output_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int INPUT_SIZE = 64,
  parameter int MAX_BURST  = 8
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_IN-1:0]               in_valid,
  input  logic [NUM_IN*INPUT_SIZE-1:0]    in_data,
  input  logic [NUM_IN*32-1:0]            in_tag,
  input  logic [NUM_IN-1:0]               in_last,
  output logic [NUM_IN-1:0]               in_ready,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [INPUT_SIZE-1:0]           out_data,
  output logic [31:0]                     out_tag,
  output logic [$clog2(NUM_IN)-1:0]       out_src,
  output logic                            out_burst_end,
  output logic                            all_done,
`ifdef ARB_BEAT_COUNT_EN
  output logic [NUM_IN*32-1:0]            beat_count,
`endif
  output logic [1:0]                      dbg_state,
  output logic [$clog2(MAX_BURST+1)-1:0]  dbg_burst_cnt
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam int SUM_W = IDX_W + 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
  logic [NUM_IN-1:0]       finished_q, finished_d;
  logic                    out_valid_q, out_valid_d;
  logic [INPUT_SIZE-1:0]   out_data_q, out_data_d;
  logic [31:0]             out_tag_q, out_tag_d;
  logic [IDX_W-1:0]        out_src_q, out_src_d;
  logic                    out_burst_end_q, out_burst_end_d;

  logic                    load_en;
  logic                    accept;
  logic                    own_valid;
  logic                    own_last;
  logic [INPUT_SIZE-1:0]   own_data;
  logic [31:0]             own_tag;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    burst_end;
  logic [IDX_W-1:0]        rr_next;
  logic                    found;
  logic [IDX_W-1:0]        pick;
  logic [SUM_W-1:0]        cand;

  // Handshake: a beat moves when valid and ready are both high at a rising edge; ready
  // never depends on valid, and a producer holds valid/data stable until it is accepted.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    own_tag   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_valid = in_valid[i];
        own_last  = in_last[i];
        own_data  = in_data[i*INPUT_SIZE +: INPUT_SIZE];
        own_tag   = in_tag[i*32 +: 32];
      end
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (cand >= SUM_W'(NUM_IN)) cand = cand - SUM_W'(NUM_IN);
      if (!found && in_valid[cand[IDX_W-1:0]] && !finished_q[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    load_en   = ~out_valid_q | out_ready;
    accept    = (state_q == S_GRANT) & load_en & own_valid;
    cnt_inc   = burst_cnt_q + 1'b1;
    burst_end = (cnt_inc == CNT_W'(MAX_BURST)) | own_last;
    rr_next   = (owner_q == IDX_W'(NUM_IN - 1)) ? '0 : owner_q + 1'b1;
    in_ready  = '0;
    if (state_q == S_GRANT && load_en) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (owner_q == IDX_W'(i)) in_ready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    finished_d  = finished_q;
    case (state_q)
      S_IDLE: begin
        if (&finished_q && !out_valid_q) begin
          state_d = S_DONE;
        end else if (found) begin
          owner_d     = pick;
          burst_cnt_d = '0;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        // A stalled output freezes the grant; an empty owner only releases when we could load.
        if (load_en) begin
          if (!own_valid) begin
            state_d  = S_IDLE;
            rr_ptr_d = rr_next;
          end else begin
            burst_cnt_d = cnt_inc;
            for (int i = 0; i < NUM_IN; i++) begin
              if (owner_q == IDX_W'(i) && own_last) finished_d[i] = 1'b1;
            end
            if (burst_end) begin
              state_d  = S_IDLE;
              rr_ptr_d = rr_next;
            end
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_tag_d       = out_tag_q;
    out_src_d       = out_src_q;
    out_burst_end_d = out_burst_end_q;
    if (load_en) begin
      out_valid_d     = accept;
      out_burst_end_d = accept & burst_end;
      if (accept) begin
        out_data_d = own_data;
        out_tag_d  = own_tag;
        out_src_d  = owner_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      owner_q         <= '0;
      rr_ptr_q        <= '0;
      burst_cnt_q     <= '0;
      finished_q      <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_tag_q       <= '0;
      out_src_q       <= '0;
      out_burst_end_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      rr_ptr_q        <= rr_ptr_d;
      burst_cnt_q     <= burst_cnt_d;
      finished_q      <= finished_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_tag_q       <= out_tag_d;
      out_src_q       <= out_src_d;
      out_burst_end_q <= out_burst_end_d;
    end
  end

`ifdef ARB_BEAT_COUNT_EN
  logic [31:0] beat_cnt_q [NUM_IN];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (!resetn) begin
        beat_cnt_q[i] <= '0;
      end else if (accept && owner_q == IDX_W'(i)) begin
        beat_cnt_q[i] <= beat_cnt_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    beat_count = '0;
    for (int i = 0; i < NUM_IN; i++) beat_count[i*32 +: 32] = beat_cnt_q[i];
  end
`endif

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_tag       = out_tag_q;
  assign out_src       = out_src_q;
  assign out_burst_end = out_burst_end_q;
  assign all_done      = (state_q == S_DONE);
  assign dbg_state     = state_q;
  assign dbg_burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_partition_output_arbiter.sv
// Directed, table-driven bench for partition_output_arbiter (NUM_IN=4, MAX_BURST=8)
// with a data scoreboard tracking every accepted beat through to the output.
module tb_partition_output_arbiter;

  localparam int NUM_IN = 4;
  localparam int DW     = 64;
  localparam int MB     = 8;
  localparam int CW     = $clog2(MB + 1);

  logic                 clk;
  logic                 resetn;
  logic [NUM_IN-1:0]    in_valid;
  logic [NUM_IN*DW-1:0] in_data;
  logic [NUM_IN*32-1:0] in_tag;
  logic [NUM_IN-1:0]    in_last;
  logic [NUM_IN-1:0]    in_ready;
  logic                 out_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic [31:0]          out_tag;
  logic [1:0]           out_src;
  logic                 out_burst_end;
  logic                 all_done;
  logic [1:0]           dbg_state;
  logic [CW-1:0]        dbg_burst_cnt;
`ifdef ARB_BEAT_COUNT_EN
  logic [NUM_IN*32-1:0] beat_count;
`endif

  partition_output_arbiter #(.NUM_IN(NUM_IN), .INPUT_SIZE(DW), .MAX_BURST(MB)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_tag        (in_tag),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_tag       (out_tag),
    .out_src       (out_src),
    .out_burst_end (out_burst_end),
    .all_done      (all_done),
`ifdef ARB_BEAT_COUNT_EN
    .beat_count    (beat_count),
`endif
    .dbg_state     (dbg_state),
    .dbg_burst_cnt (dbg_burst_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         rst_before;
    logic       rstn;
    logic [3:0] v;
    logic [3:0] l;
    logic       ordy;
    logic       ov;
    logic [1:0] src;
    logic       be;
    logic [3:0] ir;
    logic [3:0] cnt;
    logic       done;
  } vec_t;

  int           n_checks;
  int           n_fail;
  logic [31:0]  seq [NUM_IN];
  logic [95:0]  exp_q [$];
  vec_t         tbl [$];

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(string n, bit rb, logic rst, logic [3:0] v, logic [3:0] l,
                              logic o, logic ov, int src, logic be, logic [3:0] ir,
                              int cnt, logic done);
    vec_t r;
    r.name = n; r.rst_before = rb; r.rstn = rst; r.v = v; r.l = l; r.ordy = o;
    r.ov = ov; r.src = 2'(src); r.be = be; r.ir = ir; r.cnt = 4'(cnt); r.done = done;
    return r;
  endfunction

  // driver: inputs at negedge, outputs sampled 1ns later, handshakes scored for the next edge
  task automatic drive_inputs(input logic rst, input logic [3:0] v, input logic [3:0] l, input logic o);
    resetn    = rst;
    in_valid  = v;
    in_last   = l;
    out_ready = o;
    for (int i = 0; i < NUM_IN; i++) begin
      in_data[i*DW +: DW] = {32'(i), seq[i]};
      in_tag[i*32 +: 32]  = 32'hA500_0000 | (32'(i) << 16) | (seq[i] & 32'hFFFF);
    end
  endtask

  task automatic score_handshakes(input string name);
    logic [95:0] e;
    if (!resetn) return;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk({name, "_unexpected_beat"}, {out_tag, out_data}, '0);
      end else begin
        e = exp_q.pop_front();
        chk({name, "_data"}, {out_tag, out_data}, e);
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        exp_q.push_back({in_tag[i*32 +: 32], in_data[i*DW +: DW]});
        seq[i] = seq[i] + 32'd1;
      end
    end
  endtask

  task automatic do_reset();
    exp_q.delete();
    @(negedge clk);
    drive_inputs(1'b0, 4'b0, 4'b0, 1'b0);
    @(negedge clk);
    drive_inputs(1'b0, 4'b0, 4'b0, 1'b0);
    #1;
    chk("rst_out_valid", 96'(out_valid), 96'(0));
    chk("rst_in_ready", 96'(in_ready), 96'(0));
    chk("rst_all_done", 96'(all_done), 96'(0));
    chk("rst_burst_end", 96'(out_burst_end), 96'(0));
    chk("rst_out_src", 96'(out_src), 96'(0));
    chk("rst_burst_cnt", 96'(dbg_burst_cnt), 96'(0));
    chk("rst_state", 96'(dbg_state), 96'(0));
  endtask

  task automatic apply(input vec_t r);
    if (r.rst_before) do_reset();
    @(negedge clk);
    drive_inputs(r.rstn, r.v, r.l, r.ordy);
    #1;
    chk({r.name, "_out_valid"}, 96'(out_valid), 96'(r.ov));
    chk({r.name, "_in_ready"}, 96'(in_ready), 96'(r.ir));
    chk({r.name, "_burst_cnt"}, 96'(dbg_burst_cnt), 96'(r.cnt));
    chk({r.name, "_all_done"}, 96'(all_done), 96'(r.done));
    if (r.ov) begin
      chk({r.name, "_out_src"}, 96'(out_src), 96'(r.src));
      chk({r.name, "_burst_end"}, 96'(out_burst_end), 96'(r.be));
    end
    score_handshakes(r.name);
    if (!r.rstn) exp_q.delete();
  endtask

  initial begin
    vec_t r;
    int   p;
    int   g;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < NUM_IN; i++) seq[i] = 32'h100 * 32'(i + 1);
    drive_inputs(1'b0, 4'b0, 4'b0, 1'b0);

    // single stream 2, three beats, latency 1 after one IDLE cycle
    tbl.push_back(mk("s1", 1, 1, 4'b0100, 4'b0, 1, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk("s1", 0, 1, 4'b0100, 4'b0, 1, 0, 0, 0, 4'b0100, 0, 0));
    tbl.push_back(mk("s1", 0, 1, 4'b0100, 4'b0, 1, 1, 2, 0, 4'b0100, 1, 0));
    tbl.push_back(mk("s1", 0, 1, 4'b0100, 4'b0, 1, 1, 2, 0, 4'b0100, 2, 0));
    tbl.push_back(mk("s1", 0, 1, 4'b0000, 4'b0, 1, 1, 2, 0, 4'b0100, 3, 0));
    tbl.push_back(mk("s1", 0, 1, 4'b0000, 4'b0, 1, 0, 0, 0, 4'b0000, 3, 0));
    // stream 1 ends with in_last on beat 3 and is never granted again
    tbl.push_back(mk("s4", 1, 1, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk("s4", 0, 1, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0010, 0, 0));
    tbl.push_back(mk("s4", 0, 1, 4'b0010, 4'b0000, 1, 1, 1, 0, 4'b0010, 1, 0));
    tbl.push_back(mk("s4", 0, 1, 4'b0010, 4'b0010, 1, 1, 1, 0, 4'b0010, 2, 0));
    tbl.push_back(mk("s4", 0, 1, 4'b0010, 4'b0000, 1, 1, 1, 1, 4'b0000, 3, 0));
    tbl.push_back(mk("s4", 0, 1, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0000, 3, 0));
    tbl.push_back(mk("s4", 0, 1, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0000, 3, 0));
    tbl.push_back(mk("s4", 0, 1, 4'b1010, 4'b0000, 1, 0, 0, 0, 4'b0000, 3, 0));
    tbl.push_back(mk("s4", 0, 1, 4'b1010, 4'b0000, 1, 0, 0, 0, 4'b1000, 0, 0));
    tbl.push_back(mk("s4", 0, 1, 4'b0010, 4'b0000, 1, 1, 3, 0, 4'b1000, 1, 0));
    tbl.push_back(mk("s4", 0, 1, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk("s4", 0, 1, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0000, 1, 0));
    // stream 0 stalled by out_ready low for 5 cycles, valid dropping mid-stall
    tbl.push_back(mk("s3", 1, 1, 4'b0001, 4'b0, 1, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk("s3", 0, 1, 4'b0001, 4'b0, 1, 0, 0, 0, 4'b0001, 0, 0));
    tbl.push_back(mk("s3", 0, 1, 4'b0001, 4'b0, 1, 1, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk("s3", 0, 1, 4'b0001, 4'b0, 0, 1, 0, 0, 4'b0000, 2, 0));
    tbl.push_back(mk("s3", 0, 1, 4'b0001, 4'b0, 0, 1, 0, 0, 4'b0000, 2, 0));
    tbl.push_back(mk("s3", 0, 1, 4'b0000, 4'b0, 0, 1, 0, 0, 4'b0000, 2, 0));
    tbl.push_back(mk("s3", 0, 1, 4'b0000, 4'b0, 0, 1, 0, 0, 4'b0000, 2, 0));
    tbl.push_back(mk("s3", 0, 1, 4'b0001, 4'b0, 0, 1, 0, 0, 4'b0000, 2, 0));
    tbl.push_back(mk("s3", 0, 1, 4'b0001, 4'b0, 1, 1, 0, 0, 4'b0001, 2, 0));
    tbl.push_back(mk("s3", 0, 1, 4'b0001, 4'b0, 1, 1, 0, 0, 4'b0001, 3, 0));
    tbl.push_back(mk("s3", 0, 1, 4'b0000, 4'b0, 1, 1, 0, 0, 4'b0001, 4, 0));
    tbl.push_back(mk("s3", 0, 1, 4'b0000, 4'b0, 1, 0, 0, 0, 4'b0000, 4, 0));
    // reset mid-burst of stream 2 at burst_cnt=4; next grant starts from stream 0
    tbl.push_back(mk("s6", 1, 1, 4'b0100, 4'b0, 1, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk("s6", 0, 1, 4'b0100, 4'b0, 1, 0, 0, 0, 4'b0100, 0, 0));
    tbl.push_back(mk("s6", 0, 1, 4'b0100, 4'b0, 1, 1, 2, 0, 4'b0100, 1, 0));
    tbl.push_back(mk("s6", 0, 1, 4'b0100, 4'b0, 1, 1, 2, 0, 4'b0100, 2, 0));
    tbl.push_back(mk("s6", 0, 1, 4'b0100, 4'b0, 1, 1, 2, 0, 4'b0100, 3, 0));
    tbl.push_back(mk("s6", 0, 0, 4'b0100, 4'b0, 1, 1, 2, 0, 4'b0100, 4, 0));
    tbl.push_back(mk("s6", 0, 1, 4'b1111, 4'b0, 1, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk("s6", 0, 1, 4'b1111, 4'b0, 1, 0, 0, 0, 4'b0001, 0, 0));
    tbl.push_back(mk("s6", 0, 1, 4'b1111, 4'b0, 1, 1, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk("s6", 0, 1, 4'b0000, 4'b0, 1, 1, 0, 0, 4'b0001, 2, 0));
    tbl.push_back(mk("s6", 0, 1, 4'b0000, 4'b0, 1, 0, 0, 0, 4'b0000, 2, 0));
    // every stream sends in_last; all_done the cycle after out_valid falls, then sticky
    tbl.push_back(mk("s5", 1, 1, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk("s5", 0, 1, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0001, 0, 0));
    tbl.push_back(mk("s5", 0, 1, 4'b1111, 4'b1111, 1, 1, 0, 1, 4'b0000, 1, 0));
    tbl.push_back(mk("s5", 0, 1, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0010, 0, 0));
    tbl.push_back(mk("s5", 0, 1, 4'b1111, 4'b1111, 1, 1, 1, 1, 4'b0000, 1, 0));
    tbl.push_back(mk("s5", 0, 1, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0100, 0, 0));
    tbl.push_back(mk("s5", 0, 1, 4'b1111, 4'b1111, 1, 1, 2, 1, 4'b0000, 1, 0));
    tbl.push_back(mk("s5", 0, 1, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b1000, 0, 0));
    tbl.push_back(mk("s5", 0, 1, 4'b1111, 4'b1111, 1, 1, 3, 1, 4'b0000, 1, 0));
    tbl.push_back(mk("s5", 0, 1, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk("s5", 0, 1, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b0000, 1, 1));
    tbl.push_back(mk("s5", 0, 1, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b0000, 1, 1));
    tbl.push_back(mk("s5", 0, 1, 4'b1111, 4'b0000, 0, 0, 0, 0, 4'b0000, 1, 1));

    foreach (tbl[k]) apply(tbl[k]);
    chk("s5_state_done", 96'(dbg_state), 96'(2));

    // all streams continuously valid: bursts of 8 in order 0,1,2,3,0 with one bubble each
    for (int c = 0; c < 46; c++) begin
      p = c % 9;
      g = c / 9;
      if (p == 0) r = mk("s2", c == 0, 1, 4'hF, 4'h0, 1, c > 0, (g + 3) % 4, 1, 4'b0000,
                         (c > 0) ? MB : 0, 0);
      else        r = mk("s2", 0, 1, 4'hF, 4'h0, 1, p >= 2, g % 4, 0, 4'(1 << (g % 4)),
                         p - 1, 0);
      apply(r);
    end

    chk("scoreboard_drained", 96'(exp_q.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
